// File: rtl/simon_sequencer_if.sv
// rtl/simon_sequencer_if.sv - button/LED/status bundle between the Simon sequencer and the board.
interface simon_sequencer_if #(
  parameter int LEVEL_W = 5
) ();
  logic               start;
  logic [3:0]         btn;
  logic [3:0]         led;
  logic [LEVEL_W-1:0] level;
  logic               busy;
  logic               win;
  logic               lose;

  modport master (output start, output btn, input led, input level, input busy, input win, input lose);
  modport slave  (input start, input btn, output led, output level, output busy, output win, output lose);
endinterface

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game sequencer: grows an LFSR pattern, plays it, checks presses.
module simon_sequencer #(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 50_000_000,
  parameter int          GAP_CYCLES     = 25_000_000,
  parameter int          TIMEOUT_CYCLES = 500_000_000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  simon_sequencer_if.slave bus
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SHOW_CYCLES)
                           ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                           : ((SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_ECHO, S_FAIL, S_WIN
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [3:0]       led_q;
  logic             busy_q;
  logic             win_q;
  logic             lose_q;
  logic [1:0]       mem_q [MAX_LEN];

  logic [IDX_W-1:0] idx_inc;
  logic             last_step;
  logic             cnt_done;
  logic [1:0]       first_code;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    onehot = 4'b0001 << c;
  endfunction

  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign idx_inc    = idx_q + 1'b1;
  assign last_step  = (LEN_W'(idx_q) == (len_q - 1'b1));
  assign cnt_done   = (cnt_q == '0);
  // In round one, step 0 is written on the same edge that first shows it.
  assign first_code = (len_q == '0) ? lfsr_q[1:0] : mem_q[0];

  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_ADD) begin
      mem_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      lfsr_q  <= SEED;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE, S_FAIL, S_WIN: begin
          if (bus.start) begin
            state_q <= S_ADD;
            len_q   <= '0;
            led_q   <= 4'b0000;
            busy_q  <= 1'b1;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
          end else if (state_q == S_WIN) begin
            if (cnt_done) begin
              cnt_q   <= SHOW_LD;
              phase_q <= ~phase_q;
              led_q   <= phase_q ? 4'b0101 : 4'b1010;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_ADD: begin
          len_q   <= len_q + 1'b1;
          idx_q   <= '0;
          cnt_q   <= SHOW_LD;
          led_q   <= onehot(first_code);
          state_q <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (cnt_done) begin
            cnt_q   <= GAP_LD;
            led_q   <= 4'b0000;
            state_q <= S_SHOW_OFF;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SHOW_OFF: begin
          if (cnt_done) begin
            if (last_step) begin
              idx_q   <= '0;
              cnt_q   <= TMO_LD;
              state_q <= S_WAIT_IN;
            end else begin
              idx_q   <= idx_inc;
              cnt_q   <= SHOW_LD;
              led_q   <= onehot(mem_q[idx_inc]);
              state_q <= S_SHOW_ON;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT_IN: begin
          // A press on the last timeout cycle wins over the timeout.
          if (bus.btn == onehot(mem_q[idx_q])) begin
            cnt_q   <= SHOW_LD;
            led_q   <= bus.btn;
            state_q <= S_ECHO;
          end else if (bus.btn != 4'b0000 || cnt_done) begin
            led_q   <= 4'b1111;
            busy_q  <= 1'b0;
            lose_q  <= 1'b1;
            state_q <= S_FAIL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ECHO: begin
          if (cnt_done) begin
            led_q <= 4'b0000;
            if (!last_step) begin
              idx_q   <= idx_inc;
              cnt_q   <= TMO_LD;
              state_q <= S_WAIT_IN;
            end else if (len_q == LEN_W'(MAX_LEN)) begin
              cnt_q   <= SHOW_LD;
              phase_q <= 1'b0;
              led_q   <= 4'b0101;
              busy_q  <= 1'b0;
              win_q   <= 1'b1;
              state_q <= S_WIN;
            end else begin
              state_q <= S_ADD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.led   = led_q;
  assign bus.level = len_q;
  assign bus.busy  = busy_q;
  assign bus.win   = win_q;
  assign bus.lose  = lose_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - directed bench for simon_sequencer with a spec LFSR model.
module tb_simon_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] model_q;
  logic [1:0]  pat [0:3];
  int total = 0;
  int bad   = 0;

  simon_sequencer_if #(.LEVEL_W(3)) bus ();

  simon_sequencer #(
    .MAX_LEN(4), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20), .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) model_q <= !rst_n ? SEED : lfsr_step(model_q);

  function automatic logic [3:0] oh(input logic [1:0] c);
    oh = 4'b0001 << c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic play(input int len, input bit noise);
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 4; k++) begin
        check("show_led", bus.led, oh(pat[i]));
        if (noise) begin
          bus.btn   = 4'($urandom_range(1, 15));
          bus.start = 1'b1;
        end
        cyc();
      end
      for (int k = 0; k < 2; k++) begin
        check("gap_led", bus.led, 4'b0000);
        cyc();
      end
    end
    bus.btn   = 4'b0000;
    bus.start = 1'b0;
    check("wait_busy", bus.busy, 1'b1);
  endtask

  task automatic echo(input logic [1:0] code, input bit noise);
    bus.btn = oh(code);
    cyc();
    bus.btn = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      check("echo_led", bus.led, oh(code));
      if (noise) begin
        bus.btn   = 4'($urandom_range(1, 15));
        bus.start = 1'b1;
      end
      cyc();
    end
    bus.btn   = 4'b0000;
    bus.start = 1'b0;
  endtask

  task automatic round(input int r, input bit noise);
    pat[r-1] = model_q[1:0];
    check("add_busy", bus.busy, 1'b1);
    cyc();
    check("round_level", 32'(bus.level), r);
    play(r, noise);
    for (int i = 0; i < r; i++) echo(pat[i], noise);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0] wrong;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.btn   = 4'b1111;
    repeat (3) begin
      cyc();
      check("rst_led", bus.led, 4'b0000);
      check("rst_level", 32'(bus.level), 0);
      check("rst_flags", {bus.busy, bus.win, bus.lose}, 3'b000);
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.btn   = 4'b0000;
    repeat (3) begin
      cyc();
      check("idle_busy", bus.busy, 1'b0);
      check("idle_led", bus.led, 4'b0000);
    end

    // full game to WIN
    do_start();
    for (int r = 1; r <= 4; r++) round(r, 1'b0);
    check("win_flags", {bus.busy, bus.win, bus.lose}, 3'b010);
    check("win_level", 32'(bus.level), 4);
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 4; k++) begin
        check("win_blink", bus.led, (ph % 2) ? 4'b1010 : 4'b0101);
        cyc();
      end
    end

    // wrong colour in round 2
    do_start();
    round(1, 1'b0);
    pat[1] = model_q[1:0];
    cyc();
    check("r2_level", 32'(bus.level), 2);
    play(2, 1'b0);
    echo(pat[0], 1'b0);
    wrong = pat[1] + 2'd1;
    bus.btn = oh(wrong);
    cyc();
    bus.btn = 4'b0000;
    check("wrong_flags", {bus.busy, bus.win, bus.lose}, 3'b001);
    check("wrong_led", bus.led, 4'b1111);
    check("wrong_level", 32'(bus.level), 2);

    // restart from FAIL, then time out
    do_start();
    pat[0] = model_q[1:0];
    cyc();
    check("restart_level", 32'(bus.level), 1);
    play(1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      check("tmo_wait", bus.lose, 1'b0);
      if (k < 20) cyc();
    end
    cyc();
    check("tmo_lose", bus.lose, 1'b1);
    check("tmo_led", bus.led, 4'b1111);
    check("tmo_level", 32'(bus.level), 1);

    // press on the last timeout cycle is accepted
    do_start();
    pat[0] = model_q[1:0];
    cyc();
    check("prio_level", 32'(bus.level), 1);
    play(1, 1'b0);
    repeat (19) cyc();
    echo(pat[0], 1'b0);
    check("prio_lose", bus.lose, 1'b0);

    // round 2 with presses and start pulses during SHOW/ECHO
    round(2, 1'b1);
    check("noise_flags", {bus.busy, bus.lose}, 2'b10);

    // two-bit press in WAIT_IN
    pat[2] = model_q[1:0];
    cyc();
    check("r3_level", 32'(bus.level), 3);
    play(3, 1'b0);
    bus.btn = 4'b0011;
    cyc();
    bus.btn = 4'b0000;
    check("multi_lose", bus.lose, 1'b1);
    check("multi_led", bus.led, 4'b1111);
    check("multi_level", 32'(bus.level), 3);

    // reset in the middle of SHOW_ON
    do_start();
    pat[0] = model_q[1:0];
    cyc();
    check("pre_rst_led", bus.led, oh(pat[0]));
    cyc();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.btn   = 4'b1111;
    cyc();
    check("mid_rst_led", bus.led, 4'b0000);
    check("mid_rst_level", 32'(bus.level), 0);
    check("mid_rst_flags", {bus.busy, bus.win, bus.lose}, 3'b000);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.btn   = 4'b0000;
    cyc();
    cyc();
    check("post_rst_busy", bus.busy, 1'b0);
    do_start();
    pat[0] = model_q[1:0];
    cyc();
    check("post_rst_led", bus.led, oh(pat[0]));
    check("post_rst_level", 32'(bus.level), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
